// File: rtl/servant_matmul_pkg.sv
// ============================================================================
// Module      : servant_matmul_pkg
// Description : Shared types, default limits and width helpers for the
//               servant matrix-multiply sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package servant_matmul_pkg;

  localparam int unsigned c_f_row_max_def = 3;
  localparam int unsigned c_f_col_max_def = 3;
  localparam int unsigned c_s_col_max_def = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WRITE = 2'd2
  } state_t;

  function automatic int unsigned dim_width(input int unsigned max_dim);
    return $clog2(max_dim + 1);
  endfunction

  function automatic int unsigned idx_width(input int unsigned a, input int unsigned b);
    int unsigned w;
    w = $clog2(a * b);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic logic dim_ok(input int unsigned d, input int unsigned max_dim);
    return (d != 0) && (d <= max_dim);
  endfunction

endpackage

`default_nettype wire

// File: rtl/servant_matmul_if.sv
// ============================================================================
// Module      : servant_matmul_if
// Description : Control, operand-request and result-request bundle between
//               the sequencer (master) and its register/datapath peers (slave).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface servant_matmul_if import servant_matmul_pkg::*; #(
  parameter int unsigned MW  = dim_width(c_f_row_max_def),
  parameter int unsigned KW  = dim_width(c_f_col_max_def),
  parameter int unsigned NW  = dim_width(c_s_col_max_def),
  parameter int unsigned FIW = idx_width(c_f_row_max_def, c_f_col_max_def),
  parameter int unsigned SIW = idx_width(c_f_col_max_def, c_s_col_max_def),
  parameter int unsigned CIW = idx_width(c_f_row_max_def, c_s_col_max_def)
) ();

  logic           i_start;
  logic           i_abort;
  logic [MW-1:0]  i_rows;
  logic [KW-1:0]  i_inner;
  logic [NW-1:0]  i_cols;
  logic           o_busy;
  logic           o_done;
  logic           o_err;
  logic           o_op_valid;
  logic           i_op_ready;
  logic [FIW-1:0] o_f_idx;
  logic [SIW-1:0] o_s_idx;
  logic           o_acc_clr;
  logic           o_acc_last;
  logic           o_res_valid;
  logic           i_res_ready;
  logic [CIW-1:0] o_res_idx;

  modport master (
    input  i_start, i_abort, i_rows, i_inner, i_cols, i_op_ready, i_res_ready,
    output o_busy, o_done, o_err, o_op_valid, o_f_idx, o_s_idx,
           o_acc_clr, o_acc_last, o_res_valid, o_res_idx
  );

  modport slave (
    output i_start, i_abort, i_rows, i_inner, i_cols, i_op_ready, i_res_ready,
    input  o_busy, o_done, o_err, o_op_valid, o_f_idx, o_s_idx,
           o_acc_clr, o_acc_last, o_res_valid, o_res_idx
  );

endinterface

`default_nettype wire

// File: rtl/servant_matmul_idx_cnt.sv
// ============================================================================
// Module      : servant_matmul_idx_cnt
// Description : Loop counter 0..limit-1; flags the last value and wraps to 0
//               when incremented there.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module servant_matmul_idx_cnt #(
  parameter int unsigned WIDTH = 2
) (
  input  wire logic             i_clk,
  input  wire logic             i_rst_n,
  input  wire logic             i_clr,
  input  wire logic             i_inc,
  input  wire logic [WIDTH-1:0] i_limit,
  output logic                  o_wrap
);

  logic [WIDTH-1:0] r_cnt;

  assign o_wrap = (r_cnt == (i_limit - WIDTH'(1)));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= o_wrap ? '0 : (r_cnt + WIDTH'(1));
    end
  end

endmodule

`default_nettype wire

// File: rtl/servant_matmul_sched.sv
// ============================================================================
// Module      : servant_matmul_sched
// Description : Walks (i, j, k) for C = F*S, issuing one operand request per
//               MAC step and one result write per output element.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module servant_matmul_sched import servant_matmul_pkg::*; #(
  parameter int unsigned F_MATRIX_ROW_SIZE_MAX    = c_f_row_max_def,
  parameter int unsigned F_MATRIX_COLUMN_SIZE_MAX = c_f_col_max_def,
  parameter int unsigned S_MATRIX_COLUMN_SIZE_MAX = c_s_col_max_def
) (
  input  wire logic      i_clk,
  input  wire logic      i_rst_n,
  servant_matmul_if.master bus
);

  localparam int unsigned MW  = dim_width(F_MATRIX_ROW_SIZE_MAX);
  localparam int unsigned KW  = dim_width(F_MATRIX_COLUMN_SIZE_MAX);
  localparam int unsigned NW  = dim_width(S_MATRIX_COLUMN_SIZE_MAX);
  localparam int unsigned FIW = idx_width(F_MATRIX_ROW_SIZE_MAX, F_MATRIX_COLUMN_SIZE_MAX);
  localparam int unsigned SIW = idx_width(F_MATRIX_COLUMN_SIZE_MAX, S_MATRIX_COLUMN_SIZE_MAX);
  localparam int unsigned CIW = idx_width(F_MATRIX_ROW_SIZE_MAX, S_MATRIX_COLUMN_SIZE_MAX);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [MW-1:0]   r_m;
  logic [KW-1:0]   r_k;
  logic [NW-1:0]   r_n;
  logic [FIW-1:0]  r_f_base;
  logic [FIW-1:0]  r_f_idx;
  logic [SIW-1:0]  r_s_base;
  logic [SIW-1:0]  r_s_idx;
  logic [CIW-1:0]  r_res_idx;
  logic            r_done;
  logic            r_err;

  logic w_dims_ok;
  logic w_start_any;
  logic w_start_ok;
  logic w_op_hs;
  logic w_res_hs;
  logic w_i_wrap;
  logic w_j_wrap;
  logic w_k_wrap;
  logic w_last_elem;

  assign w_dims_ok   = dim_ok(32'(bus.i_rows),  F_MATRIX_ROW_SIZE_MAX)
                     & dim_ok(32'(bus.i_inner), F_MATRIX_COLUMN_SIZE_MAX)
                     & dim_ok(32'(bus.i_cols),  S_MATRIX_COLUMN_SIZE_MAX);
  assign w_start_any = (r_state == IDLE) & bus.i_start & ~bus.i_abort;
  assign w_start_ok  = w_start_any & w_dims_ok;
  assign w_op_hs     = (r_state == ISSUE) & bus.i_op_ready;
  assign w_res_hs    = (r_state == WRITE) & bus.i_res_ready;
  assign w_last_elem = w_i_wrap & w_j_wrap;

  // k is held at K-1 through WRITE and cleared by the result handshake
  servant_matmul_idx_cnt #(.WIDTH(KW)) u_k_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (w_start_ok | w_res_hs),
    .i_inc   (w_op_hs & ~w_k_wrap),
    .i_limit (r_k),
    .o_wrap  (w_k_wrap)
  );

  servant_matmul_idx_cnt #(.WIDTH(NW)) u_j_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (w_start_ok),
    .i_inc   (w_res_hs),
    .i_limit (r_n),
    .o_wrap  (w_j_wrap)
  );

  servant_matmul_idx_cnt #(.WIDTH(MW)) u_i_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (w_start_ok),
    .i_inc   (w_res_hs & w_j_wrap),
    .i_limit (r_m),
    .o_wrap  (w_i_wrap)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_start_ok) w_state_nxt = ISSUE;
      ISSUE:   if (w_op_hs && w_k_wrap) w_state_nxt = WRITE;
      WRITE:   if (w_res_hs) w_state_nxt = w_last_elem ? IDLE : ISSUE;
      default: w_state_nxt = IDLE;
    endcase
    if (bus.i_abort) w_state_nxt = IDLE;
  end

  // f_idx = f_base + k and s_idx = s_base + k*N, both advanced by addition only
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_m       <= '0;
      r_k       <= '0;
      r_n       <= '0;
      r_f_base  <= '0;
      r_f_idx   <= '0;
      r_s_base  <= '0;
      r_s_idx   <= '0;
      r_res_idx <= '0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_start_any) begin
        r_m       <= bus.i_rows;
        r_k       <= bus.i_inner;
        r_n       <= bus.i_cols;
        r_f_base  <= '0;
        r_f_idx   <= '0;
        r_s_base  <= '0;
        r_s_idx   <= '0;
        r_res_idx <= '0;
        r_err     <= ~w_dims_ok;
        r_done    <= ~w_dims_ok;
      end else begin
        if (w_op_hs && !w_k_wrap) begin
          r_f_idx <= r_f_idx + FIW'(1);
          r_s_idx <= r_s_idx + SIW'(r_n);
        end
        if (w_res_hs) begin
          r_res_idx <= r_res_idx + CIW'(1);
          if (w_j_wrap) begin
            r_f_base <= r_f_base + FIW'(r_k);
            r_f_idx  <= r_f_base + FIW'(r_k);
            r_s_base <= '0;
            r_s_idx  <= '0;
          end else begin
            r_f_idx  <= r_f_base;
            r_s_base <= r_s_base + SIW'(1);
            r_s_idx  <= r_s_base + SIW'(1);
          end
          if (w_last_elem && !bus.i_abort) r_done <= 1'b1;
        end
      end
    end
  end

  assign bus.o_busy      = (r_state != IDLE);
  assign bus.o_done      = r_done;
  assign bus.o_err       = r_err;
  assign bus.o_op_valid  = (r_state == ISSUE);
  assign bus.o_f_idx     = r_f_idx;
  assign bus.o_s_idx     = r_s_idx;
  assign bus.o_acc_clr   = (r_state == ISSUE) & (r_f_idx == r_f_base);
  assign bus.o_acc_last  = (r_state == ISSUE) & w_k_wrap;
  assign bus.o_res_valid = (r_state == WRITE);
  assign bus.o_res_idx   = r_res_idx;

endmodule

`default_nettype wire

// File: doc/servant_matmul_sched.md
# servant_matmul_sched

Sequencer for the servant matrix-multiply datapath. Computes C[M×N] = F[M×K] · S[K×N] by walking (i, j, k) and issuing one operand-pair request per MAC step to the accumulator datapath, then one result-write request per output element. Sits between the CPU-visible accelerator registers (dims, start, status) and the MAC/accumulator datapath inside servant.

## Interface
- F_MATRIX_ROW_SIZE_MAX, 3, max M
- F_MATRIX_COLUMN_SIZE_MAX, 3, max K
- S_MATRIX_COLUMN_SIZE_MAX, 3, max N
- Derived widths:
  - MW/KW/NW = $clog2(max+1)
  - FIW = $clog2(Mmax·Kmax), SIW = $clog2(Kmax·Nmax), CIW = $clog2(Mmax·Nmax), each minimum 1
- Ports:
  - i_clk  in  1  clock
  - i_rst_n  in  1  asynchronous active-low reset
  - i_start  in  1  start pulse
  - i_abort  in  1  synchronous abort
  - i_rows / i_inner / i_cols  in  MW/KW/NW  M, K, N
  - o_busy  out  1  job in progress
  - o_done  out  1  one-cycle completion pulse
  - o_err  out  1  sticky dimension error
  - o_op_valid  out  1  operand request valid
  - i_op_ready  in  1  datapath accepts operand request
  - o_f_idx  out  FIW  row-major F index i·K+k
  - o_s_idx  out  SIW  row-major S index k·N+j
  - o_acc_clr  out  1  first step of element (k=0)
  - o_acc_last  out  1  last step of element (k=K−1)
  - o_res_valid  out  1  result write request
  - i_res_ready  in  1  datapath has written result
  - o_res_idx  out  CIW  row-major C index i·N+j

## Operation
- States:
  - IDLE
  - ISSUE
  - WRITE
- IDLE:
  - i_start=1 latches M, K, N and clears o_err.
  - Any dim zero or above its max: set o_err, pulse o_done next cycle, stay IDLE, no requests.
  - Otherwise clear i, j, k and go to ISSUE.
- ISSUE:
  - o_op_valid=1.
  - On a handshake with k<K−1: k++.
  - On a handshake with k=K−1: go to WRITE.
- WRITE:
  - o_res_valid=1.
  - On handshake: k←0; j++.
  - On j wrap (j=N−1): j←0; i++.
  - After i=M−1 and j=N−1: go to IDLE and pulse o_done; otherwise go to ISSUE.
- Valid rule: o_op_valid/o_res_valid and all qualifying outputs stay stable until ready; no retraction except by abort or reset.
- Index generation:
  - Indices are computed incrementally from running base registers; no multipliers.
  - f_base advances by K per row; s_idx steps by N per k; res_idx steps by 1.
- i_start while busy: ignored, latched dims unchanged.
- i_abort:
  - In any state, next state is IDLE; valids drop next cycle.
  - No o_done; o_err unchanged.
  - Abort takes priority over a same-cycle handshake, which is still treated as consumed by the datapath.
- Reset (any time): all state and outputs return to 0, state IDLE.

## Timing
- Reset values: all outputs 0.
- Start sampled in cycle 0; ISSUE (o_busy=1, o_op_valid=1) begins in cycle 1.
- With ready always high, each element takes K+1 cycles. The last result handshake is in cycle M·N·(K+1); o_done=1 and o_busy=0 in cycle M·N·(K+1)+1.
- Error path: o_done and o_err both 1 in cycle 1; o_busy stays 0.
- o_busy is high exactly in ISSUE/WRITE.
- o_acc_clr and o_acc_last are both 1 when K=1.
- A new start is accepted in the same cycle o_done is high.

## Structure
- Package servant_matmul_pkg holds:
  - state enum (IDLE, ISSUE, WRITE)
  - width-computing constant functions
  - default max parameters
- Sub-module servant_matmul_idx_cnt:
  - generic counter with limit, increment-enable and wrap flag
  - instantiated for i, j, k alongside the base/stride registers
- Top-level FSM, abort and error logic stay in servant_matmul_sched.

## Test plan
- M=K=N=2, ready tied high:
  - f_idx sequence 0,1,0,1,2,3,2,3; s_idx 0,2,1,3,0,2,1,3
  - res_idx 0,1,2,3
  - o_done in cycle 13
- M=K=N=3 with random ready backpressure:
  - request fields stable while valid and not ready
  - 27 operand handshakes and 9 result handshakes, res_idx 0..8 in order
- Dimension errors:
  - i_inner=0: o_err=1 and o_done in cycle 1, no valids
  - i_rows=4: same response
  - next legal start clears o_err
- Start while busy:
  - second i_start with different dims mid-job has no effect
  - job completes with original dims and handshake count
- Abort:
  - i_abort during WRITE of element 4 of 3×3×3: valids 0 next cycle, no o_done, o_busy 0
  - immediate restart runs fully from res_idx 0
- Reset mid-job:
  - i_rst_n low asynchronously mid-ISSUE: all outputs 0 without a clock edge
  - after release, module idles until i_start
